// File: rtl/mul_div_seq.sv
// Sequential RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle.
module mul_div_seq #(
   parameter int XLEN = 32,
   parameter int ITER = XLEN
) (
   input  logic            clk_100M,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] result,
   output logic            result_valid,
   output logic            alu_complete
);

   localparam int CW = $clog2(ITER + 1);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   b_q;
   logic [XLEN-1:0]   mag;
   logic [2*XLEN-1:0] prod;
   logic [CW-1:0]     cnt;
   logic              neg_q;
   logic              neg_r;

   logic              is_div;
   logic              sgn_a;
   logic              sgn_b;
   logic              neg_a;
   logic              neg_b;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_step;
   logic [XLEN:0]     shl;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] div_step;
   logic [2*XLEN-1:0] mul_res;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_res;

   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      unique case (1'b1)
         (f3_q == 3'b001), (f3_q == 3'b100), (f3_q == 3'b110): begin
            sgn_a = 1'b1;
            sgn_b = 1'b1;
         end
         (f3_q == 3'b010): sgn_a = 1'b1;
         default: ;
      endcase
   end

   assign is_div   = f3_q[2];
   assign neg_a    = sgn_a & a_q[XLEN-1];
   assign neg_b    = sgn_b & b_q[XLEN-1];
   assign abs_a    = neg_a ? -a_q : a_q;
   assign abs_b    = neg_b ? -b_q : b_q;
   assign div_zero = is_div && (b_q == '0);
   assign div_ovf  = is_div && !f3_q[0] && (a_q == MIN) && (b_q == '1);

   // Multiply: low half holds the multiplier, consumed LSB first.
   assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]}
                   + (prod[0] ? {1'b0, mag} : '0);
   assign mul_step = {mul_sum, prod[XLEN-1:1]};

   // Divide: high half is the partial remainder, low half dividend/quotient.
   assign shl  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
   assign diff = shl - {1'b0, mag};
   assign div_step = diff[XLEN]
                   ? {shl[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                   : {diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};

   assign mul_res = neg_q ? -prod : prod;
   assign quo     = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
   assign rem     = neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];

   always_comb begin
      fix_res = '0;
      unique case (1'b1)
         (f3_q == 3'b000):            fix_res = mul_res[XLEN-1:0];
         (!f3_q[2] && f3_q != 3'b0):  fix_res = mul_res[2*XLEN-1:XLEN];
         (f3_q[2] && !f3_q[1]):       fix_res = quo;
         (f3_q[2] && f3_q[1]):        fix_res = rem;
         default: ;
      endcase
   end

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = PREP;
         PREP: state_nxt = (div_zero || div_ovf) ? FIX : CALC;
         CALC: if (cnt == CW'(ITER - 1)) state_nxt = FIX;
         FIX:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      alu_complete = (state == IDLE);
   end

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         f3_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         mag          <= '0;
         prod         <= '0;
         cnt          <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  f3_q <= funct3;
                  a_q  <= op_a;
                  b_q  <= op_b;
               end
            end
            PREP: begin
               cnt   <= '0;
               neg_q <= neg_a ^ neg_b;
               neg_r <= neg_a;
               mag   <= is_div ? abs_b : abs_a;
               if (div_zero) begin
                  prod  <= {a_q, {XLEN{1'b1}}};
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
               end else if (div_ovf) begin
                  prod  <= {{XLEN{1'b0}}, MIN};
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
               end else begin
                  prod <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
               end
            end
            CALC: begin
               cnt  <= cnt + CW'(1);
               prod <= is_div ? div_step : mul_step;
            end
            FIX: begin
               result       <= fix_res;
               result_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq.
// Random and directed RV32M ops against a 64-bit arithmetic model.
module tb_mul_div_seq;

   logic        clk_100M;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] result;
   logic        result_valid;
   logic        alu_complete;

   int vectors;
   int miscompares;

   mul_div_seq #(.XLEN(32), .ITER(32)) dut (
      .clk_100M     (clk_100M),
      .rst_n        (rst_n),
      .start        (start),
      .funct3       (funct3),
      .op_a         (op_a),
      .op_b         (op_b),
      .result       (result),
      .result_valid (result_valid),
      .alu_complete (alu_complete)
   );

   initial clk_100M = 1'b0;
   always #5 clk_100M = ~clk_100M;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = 0;
      case (f)
         3'd0: p = ua * ub;
         3'd1: p = (sa * sb) >>> 32;
         3'd2: p = (sa * ub) >>> 32;
         3'd3: p = (ua * ub) >> 32;
         3'd4: p = (b == 0) ? -1 : sa / sb;
         3'd5: p = (b == 0) ? -1 : ua / ub;
         3'd6: p = (b == 0) ? sa : sa % sb;
         default: p = (b == 0) ? ua : ua % ub;
      endcase
      return p[31:0];
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f[2] && b == 0) return 2;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return 2;
      return 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Called on a negedge; returns on the first negedge with alu_complete high.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
      logic [31:0] exp;
      int          lat;
      int          pulses;
      exp    = ref_model(f, a, b);
      funct3 = f;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      @(negedge clk_100M);
      start  = 1'b0;
      funct3 = 3'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
      lat    = 0;
      pulses = 0;
      while (alu_complete === 1'b0 && lat < 100) begin
         lat++;
         if (result_valid !== 1'b0) pulses++;
         if (poke && lat == 10) begin
            start  = 1'b1;
            funct3 = ~f;
            op_a   = ~a;
         end
         @(negedge clk_100M);
         start = 1'b0;
      end
      check($sformatf("latency f%0d", f), 32'(lat), 32'(ref_lat(f, a, b)));
      check("busy_valid", 32'(pulses), 32'd0);
      check("valid_pulse", {31'b0, result_valid}, 32'd1);
      check($sformatf("result f%0d %h %h", f, a, b), result, exp);
   endtask

   initial begin
      bit bad;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      funct3      = 3'd0;
      op_a        = 32'h0;
      op_b        = 32'h0;
      #3;
      check("rst_complete", {31'b0, alu_complete}, 32'd1);
      check("rst_result", result, 32'h0);
      check("rst_valid", {31'b0, result_valid}, 32'd0);
      @(negedge clk_100M);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk_100M);
         check("idle_complete", {31'b0, alu_complete}, 32'd1);
         check("idle_valid", {31'b0, result_valid}, 32'd0);
      end

      run_op(3'd0, 32'd7, 32'd6, 1'b0);
      check("mul_7x6", result, 32'd42);
      @(negedge clk_100M);
      check("valid_drop", {31'b0, result_valid}, 32'd0);
      check("result_hold", result, 32'd42);

      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("mulh_m1", result, 32'h0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("mulhu_m1", result, 32'hFFFF_FFFE);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_m7", result, 32'hFFFF_FFFD);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("rem_m7", result, 32'hFFFF_FFFF);
      run_op(3'd5, 32'h1234, 32'd0, 1'b0);
      check("divu_z", result, 32'hFFFF_FFFF);
      run_op(3'd7, 32'h1234, 32'd0, 1'b0);
      check("remu_z", result, 32'h1234);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf", result, 32'h8000_0000);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("rem_ovf", result, 32'h0);
      run_op(3'd5, 32'd1000, 32'd7, 1'b1);
      check("divu_poke", result, 32'd142);
      run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b1);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 3)) @(negedge clk_100M);
         run_op(3'($urandom), pick(), pick(), bit'($urandom_range(0, 1)));
      end

      run_op(3'd0, 32'd9, 32'd9, 1'b0);
      funct3 = 3'd0;
      op_a   = 32'd9;
      op_b   = 32'd9;
      start  = 1'b1;
      @(negedge clk_100M);
      start = 1'b0;
      repeat (10) @(negedge clk_100M);
      rst_n = 1'b0;
      #1;
      check("abort_complete", {31'b0, alu_complete}, 32'd1);
      check("abort_result", result, 32'h0);
      check("abort_valid", {31'b0, result_valid}, 32'd0);
      @(negedge clk_100M);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk_100M);
         if (result_valid !== 1'b0 || alu_complete !== 1'b1) bad = 1'b1;
      end
      check("abort_quiet", {31'b0, bad}, 32'd0);
      run_op(3'd0, 32'd3, 32'd5, 1'b0);
      check("mul_3x5", result, 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
